// File: rtl/debounce_pkg.sv
// Shared defaults and counter-width helper for the debounce bank.
package debounce_pkg;

   localparam int DEF_N_CH        = 4;
   localparam int DEF_STABLE_CYC  = 4;
   localparam int DEF_LONG_CYC    = 50_000_000;
   localparam int DEF_SYNC_STAGES = 2;

   // Width of a counter over n states; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, edge pulses and long-press detect.
// Latency pb step -> db_o is SYNC_STAGES+STABLE_CYC edges; all outputs registered.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int STABLE_CYC  = DEF_STABLE_CYC,
   parameter int LONG_CYC    = DEF_LONG_CYC,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o
);

   localparam int SW = cnt_w(STABLE_CYC);
   localparam int HW = cnt_w(LONG_CYC + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [SW-1:0]          stab_q, stab_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic                   db_q, db_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   long_q, long_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      stab_d = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != db_q) begin
         if (stab_q == STAB_MAX) begin
            db_d   = ~db_q;
            rise_d = ~db_q;
            fall_d = db_q;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end
   end

   // Hold counter saturates, so the long pulse fires once per press.
   always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (db_q) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
         long_d = (hold_q == HOLD_PRE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         stab_q <= '0;
         hold_q <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         long_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pb_i};
         stab_q <= stab_d;
         hold_q <= hold_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         long_q <= long_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign long_o = long_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounce channels with rise/fall/long-press pulses.
// Latency SYNC_STAGES+STABLE_CYC edges; no backpressure, outputs are registered levels/pulses.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int STABLE_CYC  = DEF_STABLE_CYC,
   parameter int LONG_CYC    = DEF_LONG_CYC,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb,
   output logic [N_CH-1:0] db_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic [N_CH-1:0] long_pulse
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .STABLE_CYC  (STABLE_CYC),
         .LONG_CYC    (LONG_CYC),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .pb_i   (pb[g]),
         .db_o   (db_out[g]),
         .rise_o (rise_pulse[g]),
         .fall_o (fall_pulse[g]),
         .long_o (long_pulse[g])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench: stimulus queues expected pulse events, a monitor pops and compares them.
module tb_debounce_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pb;
   logic [3:0] db_out, rise_pulse, fall_pulse, long_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      logic [3:0] r;
      logic [3:0] f;
      logic [3:0] l;
   } ev_t;

   ev_t exp_q[$];

   debounce_bank #(
      .N_CH        (4),
      .STABLE_CYC  (4),
      .LONG_CYC    (20),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pb         (pb),
      .db_out     (db_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .long_pulse (long_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_ev(input int c, input logic [3:0] r, input logic [3:0] f,
                          input logic [3:0] l);
      ev_t e;
      e.cyc = c;
      e.r   = r;
      e.f   = f;
      e.l   = l;
      exp_q.push_back(e);
   endtask

   initial begin
      int         c;
      logic [8:0] bounce;
      rst = 1'b0;
      pb  = 4'b0000;

      fork
         forever begin
            @(negedge clk);
            if ((rise_pulse | fall_pulse | long_pulse) != 4'b0000) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", int'({rise_pulse, fall_pulse, long_pulse}), 0);
               end else begin
                  ev_t e;
                  e = exp_q.pop_front();
                  check("pulse_cycle", cyc, e.cyc);
                  check("pulse_rfl", int'({rise_pulse, fall_pulse, long_pulse}),
                        int'({e.r, e.f, e.l}));
               end
            end
         end
      join_none

      // Reset state
      tick(3);
      check("rst_db_out", int'(db_out), 0);
      check("rst_rise", int'(rise_pulse), 0);
      check("rst_fall", int'(fall_pulse), 0);
      check("rst_long", int'(long_pulse), 0);
      rst = 1'b1;
      tick(3);

      // Clean step on ch0
      c = cyc;
      pb[0] = 1'b1;
      push_ev(c + 6, 4'b0001, 4'b0000, 4'b0000);
      tick(5);
      check("step_db_before", int'(db_out[0]), 0);
      tick(1);
      check("step_db_after", int'(db_out[0]), 1);
      pb[0] = 1'b0;
      push_ev(c + 12, 4'b0000, 4'b0001, 4'b0000);
      tick(12);

      // Short 3-cycle glitch on ch1 is rejected
      pb[1] = 1'b1;
      tick(3);
      pb[1] = 1'b0;
      tick(3);
      check("glitch_db_mid", int'(db_out[1]), 0);
      tick(8);
      check("glitch_db_end", int'(db_out[1]), 0);

      // Bounce on ch2
      c = cyc;
      bounce = 9'b1_1110_1101;
      for (int i = 0; i < 9; i++) begin
         pb[2] = bounce[i];
         tick(1);
      end
      push_ev(c + 11, 4'b0100, 4'b0000, 4'b0000);
      tick(1);
      check("bounce_db_before", int'(db_out[2]), 0);
      tick(1);
      check("bounce_db_after", int'(db_out[2]), 1);
      tick(9);
      pb[2] = 1'b0;
      push_ev(c + 26, 4'b0000, 4'b0100, 4'b0000);
      tick(12);

      // Long press on ch3
      c = cyc;
      pb[3] = 1'b1;
      push_ev(c + 6,  4'b1000, 4'b0000, 4'b0000);
      push_ev(c + 26, 4'b0000, 4'b0000, 4'b1000);
      tick(36);
      pb[3] = 1'b0;
      push_ev(c + 42, 4'b0000, 4'b1000, 4'b0000);
      tick(12);

      // All channels together
      c = cyc;
      pb = 4'b1111;
      push_ev(c + 6, 4'b1111, 4'b0000, 4'b0000);
      tick(10);
      check("all_db_high", int'(db_out), 15);
      pb = 4'b0000;
      push_ev(c + 16, 4'b0000, 4'b1111, 4'b0000);
      tick(12);

      // Reset mid-count on ch0 while ch3 is debounced high
      c = cyc;
      pb = 4'b1000;
      push_ev(c + 6, 4'b1000, 4'b0000, 4'b0000);
      tick(8);
      pb[0] = 1'b1;
      tick(4);
      rst = 1'b0;
      #1;
      check("midrst_db_out", int'(db_out), 0);
      check("midrst_rise", int'(rise_pulse), 0);
      check("midrst_fall", int'(fall_pulse), 0);
      check("midrst_long", int'(long_pulse), 0);
      tick(3);
      rst = 1'b1;
      push_ev(c + 21, 4'b1001, 4'b0000, 4'b0000);
      tick(10);
      check("postrst_db_out", int'(db_out), 9);
      pb = 4'b0000;
      push_ev(c + 31, 4'b0000, 4'b1001, 4'b0000);
      tick(12);

      check("events_outstanding", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter STABLE_CYC, default 4, consecutive agreeing samples required to change a debounced level (2..65535).
REQ-003 SHALL have parameter LONG_CYC, default 50_000_000, cycles of continuous debounced-high before a long-press pulse (> STABLE_CYC).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (2..3).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pb  input  N_CH  raw asynchronous button/switch inputs.
REQ-008 SHALL have port db_out  output  N_CH  debounced level per channel.
REQ-009 SHALL have port rise_pulse  output  N_CH  one-cycle pulse when db_out goes 0->1.
REQ-010 SHALL have port fall_pulse  output  N_CH  one-cycle pulse when db_out goes 1->0.
REQ-011 SHALL have port long_pulse  output  N_CH  one-cycle pulse when db_out has been 1 for LONG_CYC cycles.

Function
REQ-012 SHALL pass each pb bit through SYNC_STAGES flops; the last stage output is the sampled level s.
REQ-013 SHALL keep, per channel, a stability counter of width $clog2(STABLE_CYC), cleared whenever s equals db_out.
REQ-014 SHALL increment the stability counter on each edge where s differs from db_out and the counter is below STABLE_CYC-1.
REQ-015 SHALL, on an edge where s differs from db_out and the counter equals STABLE_CYC-1, invert db_out and clear the counter.
REQ-016 SHALL yield latency from a clean pb step to db_out change of exactly SYNC_STAGES+STABLE_CYC clock edges.
REQ-017 SHALL restart the stability count from zero whenever s returns to db_out before the threshold (glitch shorter than STABLE_CYC samples is rejected).
REQ-018 SHALL assert rise_pulse/fall_pulse registered, high for exactly one cycle, on the same edge db_out changes.
REQ-019 SHALL keep, per channel, a hold counter of width $clog2(LONG_CYC+1), cleared while db_out is 0.
REQ-020 SHALL increment the hold counter while db_out is 1, saturating at LONG_CYC.
REQ-021 SHALL assert long_pulse for one cycle on the edge the hold counter reaches LONG_CYC; no repeat until db_out falls and rises again.
REQ-022 SHALL operate channels fully independently; simultaneous events on several channels produce simultaneous pulses.
REQ-023 SHALL never assert rise_pulse and fall_pulse together on one channel.

Reset
REQ-024 SHALL, while rst is low, force synchroniser flops, counters, db_out, rise_pulse, fall_pulse and long_pulse to 0.
REQ-025 SHALL, on reset mid-operation, abandon any in-progress count; no pulse generated by reset itself.
REQ-026 SHALL, after release with pb held high, raise db_out SYNC_STAGES+STABLE_CYC edges later with a rise_pulse.

Structure
REQ-027 SHALL place default parameter constants and counter-width helper functions in shared package debounce_pkg.
REQ-028 SHALL implement one channel in sub-module debounce_ch, instantiated N_CH times via generate.
REQ-029 SHALL use only registered outputs; no combinational path from pb to any output.

Verification (N_CH=4, STABLE_CYC=4, LONG_CYC=20, SYNC_STAGES=2)
REQ-030 SHALL cover: pb[0] 0->1 clean step -> db_out[0]=1 and rise_pulse[0]=1 exactly 6 edges later, pulse width 1.
REQ-031 SHALL cover: pb[1] high 3 cycles then low -> db_out[1] stays 0, no pulses.
REQ-032 SHALL cover: pb[2] bounce 1,0,1,1,0,1,1,1,1 per cycle -> single rise_pulse[2], 6 edges after final rising sample.
REQ-033 SHALL cover: pb[3] held high 30 cycles after debounce -> long_pulse[3] once, 20 edges after db_out rise; release -> fall_pulse[3] once.
REQ-034 SHALL cover: pb=4'b1111 simultaneous -> all four rise_pulse bits on same edge.
REQ-035 SHALL cover: rst low mid-count (counter=2) -> all outputs 0 immediately; after release with pb high, rise 6 edges later.
